// File: rtl/mempool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mempool_pkg
// Purpose  : Shared TCDM types and defaults for the cluster memory path.
// Revision : 1.0
// ============================================================================
package mempool_pkg;

  localparam int unsigned TcdmAddrWidth       = 32;
  localparam int unsigned TcdmDataWidth       = 32;
  localparam int unsigned TcdmBeWidth         = TcdmDataWidth / 8;
  localparam int unsigned MetaTagWidth        = 5;
  localparam int unsigned MaxOutstandingLoads = 4;

  typedef logic [TcdmAddrWidth-1:0] addr_t;
  typedef logic [TcdmDataWidth-1:0] data_t;
  typedef logic [TcdmBeWidth-1:0]   be_t;
  typedef logic [MetaTagWidth-1:0]  meta_t;

endpackage
`default_nettype wire

// File: rtl/tcdm_master_shim.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_master_shim
// Purpose  : Core valid/ready port to TCDM req/gnt master, with load credits
//            and an in-order response slot array carrying per-load metadata.
// Revision : 1.0
// ============================================================================
module tcdm_master_shim
  import mempool_pkg::*;
#(
  parameter int unsigned AddrWidth      = TcdmAddrWidth,
  parameter int unsigned DataWidth      = TcdmDataWidth,
  parameter int unsigned MetaWidth      = MetaTagWidth,
  parameter int unsigned MaxOutstanding = MaxOutstandingLoads
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  input  logic [MetaWidth-1:0]   req_meta_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [DataWidth-1:0]   resp_rdata_o,
  output logic [MetaWidth-1:0]   resp_meta_o,
  output logic                   tcdm_req_o,
  output logic [AddrWidth-1:0]   tcdm_addr_o,
  output logic                   tcdm_wen_o,
  output logic [DataWidth-1:0]   tcdm_wdata_o,
  output logic [DataWidth/8-1:0] tcdm_be_o,
  input  logic                   tcdm_gnt_i,
  input  logic                   tcdm_vld_i,
  input  logic [DataWidth-1:0]   tcdm_rdata_i
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [MetaWidth-1:0]      meta_q  [MaxOutstanding];
  logic [DataWidth-1:0]      rdata_q [MaxOutstanding];
  logic [MaxOutstanding-1:0] filled_q, filled_d;
  logic [PtrWidth-1:0]       iss_ptr_q, iss_ptr_d;
  logic [PtrWidth-1:0]       ret_ptr_q, ret_ptr_d;
  logic [PtrWidth-1:0]       pop_ptr_q, pop_ptr_d;
  logic [CntWidth-1:0]       credits_q, credits_d;

  logic can_issue, load_gnt, pop;

  // Pointers wrap explicitly so the slot count need not be a power of two.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign can_issue    = req_write_i | (credits_q < CntWidth'(MaxOutstanding));
  assign tcdm_req_o   = req_valid_i & can_issue & ~rst_i;
  assign req_ready_o  = tcdm_req_o & tcdm_gnt_i;
  assign tcdm_addr_o  = req_addr_i;
  assign tcdm_wen_o   = req_write_i;
  assign tcdm_wdata_o = req_wdata_i;
  assign tcdm_be_o    = req_be_i;

  assign load_gnt     = req_ready_o & ~req_write_i;
  assign resp_valid_o = filled_q[pop_ptr_q] & ~rst_i;
  assign resp_rdata_o = rdata_q[pop_ptr_q];
  assign resp_meta_o  = meta_q[pop_ptr_q];
  assign pop          = resp_valid_o & resp_ready_i;

  always_comb begin
    filled_d  = filled_q;
    iss_ptr_d = iss_ptr_q;
    ret_ptr_d = ret_ptr_q;
    pop_ptr_d = pop_ptr_q;
    credits_d = credits_q;
    if (load_gnt) begin
      filled_d[iss_ptr_q] = 1'b0;
      iss_ptr_d           = ptr_inc(iss_ptr_q);
    end
    if (tcdm_vld_i) begin
      filled_d[ret_ptr_q] = 1'b1;
      ret_ptr_d           = ptr_inc(ret_ptr_q);
    end
    if (pop) begin
      filled_d[pop_ptr_q] = 1'b0;
      pop_ptr_d           = ptr_inc(pop_ptr_q);
    end
    case ({load_gnt, pop})
      2'b10:   credits_d = credits_q + CntWidth'(1);
      2'b01:   credits_d = credits_q - CntWidth'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filled_q  <= '0;
      iss_ptr_q <= '0;
      ret_ptr_q <= '0;
      pop_ptr_q <= '0;
      credits_q <= '0;
    end else begin
      filled_q  <= filled_d;
      iss_ptr_q <= iss_ptr_d;
      ret_ptr_q <= ret_ptr_d;
      pop_ptr_q <= pop_ptr_d;
      credits_q <= credits_d;
    end
  end

  // Payload storage needs no reset: the filled bits gate its visibility.
  always_ff @(posedge clk_i) begin
    if (load_gnt)   meta_q[iss_ptr_q]  <= req_meta_i;
    if (tcdm_vld_i) rdata_q[ret_ptr_q] <= tcdm_rdata_i;
  end

`ifndef SYNTHESIS
  // Granted-but-unreturned loads = credits minus slots already filled.
  a_vld_has_pending: assert property (@(posedge clk_i) disable iff (rst_i)
    tcdm_vld_i |-> (int'(credits_q) > $countones(filled_q)));
  a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    credits_q <= CntWidth'(MaxOutstanding));
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_valid_i && !req_ready_o) |=> (!req_valid_i ||
      ($stable(req_addr_i) && $stable(req_write_i) && $stable(req_wdata_i) &&
       $stable(req_be_i) && $stable(req_meta_i))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcdm_master_shim.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcdm_master_shim
// Purpose  : Directed vector table on a 4-slot shim, randomized reference-model
//            run on a 3-slot shim.
// Revision : 1.0
// ============================================================================
module tb_tcdm_master_shim;
  import mempool_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  // ---- DUT A: 4 slots, directed ----
  logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata, a_tcdm_addr, a_tcdm_wdata, a_tcdm_rdata;
  logic [3:0]  a_req_be, a_tcdm_be;
  logic [4:0]  a_req_meta, a_resp_meta;
  logic        a_tcdm_req, a_tcdm_wen, a_tcdm_gnt, a_tcdm_vld;

  // ---- DUT B: 3 slots, randomized ----
  logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata, b_tcdm_addr, b_tcdm_wdata, b_tcdm_rdata;
  logic [3:0]  b_req_be, b_tcdm_be;
  logic [4:0]  b_req_meta, b_resp_meta;
  logic        b_tcdm_req, b_tcdm_wen, b_tcdm_gnt, b_tcdm_vld;

  tcdm_master_shim #(.AddrWidth(32), .DataWidth(32), .MetaWidth(5), .MaxOutstanding(4)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
    .req_write_i(a_req_write), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
    .req_meta_i(a_req_meta), .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
    .resp_rdata_o(a_resp_rdata), .resp_meta_o(a_resp_meta), .tcdm_req_o(a_tcdm_req),
    .tcdm_addr_o(a_tcdm_addr), .tcdm_wen_o(a_tcdm_wen), .tcdm_wdata_o(a_tcdm_wdata),
    .tcdm_be_o(a_tcdm_be), .tcdm_gnt_i(a_tcdm_gnt), .tcdm_vld_i(a_tcdm_vld),
    .tcdm_rdata_i(a_tcdm_rdata)
  );

  tcdm_master_shim #(.AddrWidth(32), .DataWidth(32), .MetaWidth(5), .MaxOutstanding(3)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
    .req_write_i(b_req_write), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
    .req_meta_i(b_req_meta), .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
    .resp_rdata_o(b_resp_rdata), .resp_meta_o(b_resp_meta), .tcdm_req_o(b_tcdm_req),
    .tcdm_addr_o(b_tcdm_addr), .tcdm_wen_o(b_tcdm_wen), .tcdm_wdata_o(b_tcdm_wdata),
    .tcdm_be_o(b_tcdm_be), .tcdm_gnt_i(b_tcdm_gnt), .tcdm_vld_i(b_tcdm_vld),
    .tcdm_rdata_i(b_tcdm_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v, w;
    logic [31:0] addr;
    logic [4:0]  meta;
    logic        gnt, vld;
    logic [31:0] rdata;
    logic        rr;
    logic        treq, rdy, rv;
    logic [4:0]  rmeta;
    logic [31:0] rdat;
    int          cred;
  } vec_t;

  function automatic vec_t mk(input logic v, w, input logic [31:0] addr, input logic [4:0] meta,
                              input logic gnt, vld, input logic [31:0] rdata, input logic rr,
                              input logic treq, rdy, rv, input logic [4:0] rmeta,
                              input logic [31:0] rdat, input int cred);
    vec_t t;
    t.v = v; t.w = w; t.addr = addr; t.meta = meta; t.gnt = gnt; t.vld = vld;
    t.rdata = rdata; t.rr = rr; t.treq = treq; t.rdy = rdy; t.rv = rv;
    t.rmeta = rmeta; t.rdat = rdat; t.cred = cred;
    return t;
  endfunction

  localparam logic [31:0] WDATA = 32'h1234_5678;
  localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001, A2 = 32'hA000_0002;
  localparam logic [31:0] A3 = 32'hA000_0003, A4 = 32'hA000_0004;

  vec_t tbl [27];

  // Random-phase model state: granted loads awaiting return, returned awaiting pop.
  logic [4:0]  pend_q [$];
  logic [36:0] ret_q  [$];

  initial begin
    //        v  w  addr   meta gnt vld rdata        rr | treq rdy rv rmeta rdat         cred
    tbl[0]  = mk(1, 0, 32'h100, 5'd3, 1, 0, 32'h0,        0,  1, 1, 0, 5'd0, 32'h0,        0); // single load
    tbl[1]  = mk(0, 0, 32'h0,   5'd0, 0, 0, 32'h0,        0,  0, 0, 0, 5'd0, 32'h0,        1);
    tbl[2]  = mk(0, 0, 32'h0,   5'd0, 0, 1, 32'hDEADBEEF, 0,  0, 0, 0, 5'd0, 32'h0,        1);
    tbl[3]  = mk(0, 0, 32'h0,   5'd0, 0, 0, 32'h0,        1,  0, 0, 1, 5'd3, 32'hDEADBEEF, 1);
    tbl[4]  = mk(0, 0, 32'h0,   5'd0, 0, 0, 32'h0,        0,  0, 0, 0, 5'd0, 32'h0,        0);
    tbl[5]  = mk(1, 0, 32'h400, 5'd0, 1, 0, 32'h0,        0,  1, 1, 0, 5'd0, 32'h0,        0); // credit limit
    tbl[6]  = mk(1, 0, 32'h404, 5'd1, 1, 1, A0,           0,  1, 1, 0, 5'd0, 32'h0,        1);
    tbl[7]  = mk(1, 0, 32'h408, 5'd2, 1, 1, A1,           0,  1, 1, 1, 5'd0, A0,           2);
    tbl[8]  = mk(1, 0, 32'h40C, 5'd3, 1, 1, A2,           0,  1, 1, 1, 5'd0, A0,           3);
    tbl[9]  = mk(1, 0, 32'h410, 5'd4, 1, 1, A3,           0,  0, 0, 1, 5'd0, A0,           4);
    tbl[10] = mk(1, 0, 32'h410, 5'd4, 1, 0, 32'h0,        0,  0, 0, 1, 5'd0, A0,           4);
    tbl[11] = mk(1, 0, 32'h410, 5'd4, 1, 0, 32'h0,        1,  0, 0, 1, 5'd0, A0,           4);
    tbl[12] = mk(1, 0, 32'h410, 5'd4, 1, 0, 32'h0,        0,  1, 1, 1, 5'd1, A1,           3);
    tbl[13] = mk(1, 1, 32'h200, 5'd0, 1, 0, 32'h0,        0,  1, 1, 1, 5'd1, A1,           4); // store at full credits
    tbl[14] = mk(0, 0, 32'h0,   5'd0, 0, 1, A4,           0,  0, 0, 1, 5'd1, A1,           4);
    tbl[15] = mk(0, 0, 32'h0,   5'd0, 0, 0, 32'h0,        1,  0, 0, 1, 5'd1, A1,           4);
    tbl[16] = mk(0, 0, 32'h0,   5'd0, 0, 0, 32'h0,        1,  0, 0, 1, 5'd2, A2,           3);
    tbl[17] = mk(0, 0, 32'h0,   5'd0, 0, 0, 32'h0,        1,  0, 0, 1, 5'd3, A3,           2);
    tbl[18] = mk(0, 0, 32'h0,   5'd0, 0, 0, 32'h0,        1,  0, 0, 1, 5'd4, A4,           1);
    tbl[19] = mk(0, 0, 32'h0,   5'd0, 0, 0, 32'h0,        1,  0, 0, 0, 5'd0, 32'h0,        0);
    tbl[20] = mk(1, 0, 32'h300, 5'd7, 0, 0, 32'h0,        0,  1, 0, 0, 5'd0, 32'h0,        0); // grant withheld
    tbl[21] = mk(1, 0, 32'h300, 5'd7, 0, 0, 32'h0,        0,  1, 0, 0, 5'd0, 32'h0,        0);
    tbl[22] = mk(1, 0, 32'h300, 5'd7, 0, 0, 32'h0,        0,  1, 0, 0, 5'd0, 32'h0,        0);
    tbl[23] = mk(1, 0, 32'h300, 5'd7, 1, 0, 32'h0,        0,  1, 1, 0, 5'd0, 32'h0,        0);
    tbl[24] = mk(0, 0, 32'h0,   5'd0, 0, 1, 32'h55,       0,  0, 0, 0, 5'd0, 32'h0,        1);
    tbl[25] = mk(0, 0, 32'h0,   5'd0, 0, 0, 32'h0,        1,  0, 0, 1, 5'd7, 32'h55,       1);
    tbl[26] = mk(0, 0, 32'h0,   5'd0, 0, 0, 32'h0,        0,  0, 0, 0, 5'd0, 32'h0,        0);

    // Reset held two cycles with a pending load on A.
    rst_i = 1'b1;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h50; a_req_wdata = WDATA;
    a_req_be = 4'hF; a_req_meta = 5'd9; a_tcdm_gnt = 1'b1; a_tcdm_vld = 1'b0;
    a_tcdm_rdata = '0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_req_be = '0; b_req_meta = '0; b_tcdm_gnt = 1'b0; b_tcdm_vld = 1'b0;
    b_tcdm_rdata = '0; b_resp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check("rst_treq", a_tcdm_req, 0);
      check("rst_rdy", a_req_ready, 0);
      check("rst_rvalid", a_resp_valid, 0);
      check("rst_rvalid_b", b_resp_valid, 0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; a_req_valid = 1'b0; a_tcdm_gnt = 1'b0;
    @(negedge clk_i);
    check("post_rst_credits", 64'(dut_a.credits_q), 0);
    check("post_rst_rvalid", a_resp_valid, 0);

    // Directed vectors on A.
    for (int i = 0; i < 27; i++) begin
      @(posedge clk_i); #1;
      a_req_valid = tbl[i].v; a_req_write = tbl[i].w; a_req_addr = tbl[i].addr;
      a_req_meta = tbl[i].meta; a_tcdm_gnt = tbl[i].gnt; a_tcdm_vld = tbl[i].vld;
      a_tcdm_rdata = tbl[i].rdata; a_resp_ready = tbl[i].rr;
      @(negedge clk_i);
      check($sformatf("v%0d_treq", i), a_tcdm_req, tbl[i].treq);
      check($sformatf("v%0d_rdy", i), a_req_ready, tbl[i].rdy);
      check($sformatf("v%0d_rvalid", i), a_resp_valid, tbl[i].rv);
      check($sformatf("v%0d_credits", i), 64'(dut_a.credits_q), 64'(tbl[i].cred));
      check($sformatf("v%0d_wen", i), a_tcdm_wen, tbl[i].w);
      check($sformatf("v%0d_addr", i), a_tcdm_addr, tbl[i].addr);
      check($sformatf("v%0d_wdata", i), a_tcdm_wdata, WDATA);
      check($sformatf("v%0d_be", i), a_tcdm_be, 4'hF);
      if (tbl[i].rv) begin
        check($sformatf("v%0d_rmeta", i), a_resp_meta, tbl[i].rmeta);
        check($sformatf("v%0d_rdata", i), a_resp_rdata, tbl[i].rdat);
      end
    end
    @(posedge clk_i); #1;
    a_req_valid = 1'b0; a_tcdm_vld = 1'b0; a_resp_ready = 1'b0;

    // Randomized run on B against a queue model.
    begin
      int   loads_done = 0;
      int   cyc = 0;
      int   simul = 0;
      int   cred;
      logic held = 1'b0;
      logic e_treq, e_rdy, e_rv, e_pop;
      logic [36:0] head;
      while ((loads_done < 40 || pend_q.size() > 0 || ret_q.size() > 0) && cyc < 3000) begin
        @(posedge clk_i); #1;
        cyc++;
        if (!held) begin
          if (loads_done < 40 && $urandom_range(0, 3) != 0) begin
            b_req_valid = 1'b1;
            b_req_write = ($urandom_range(0, 4) == 0);
            b_req_addr  = $urandom;
            b_req_wdata = $urandom;
            b_req_be    = 4'($urandom);
            b_req_meta  = 5'($urandom);
          end else begin
            b_req_valid = 1'b0;
          end
        end
        b_tcdm_gnt   = ($urandom_range(0, 2) != 0);
        b_tcdm_vld   = (pend_q.size() > 0) && ($urandom_range(0, 1) == 1);
        b_tcdm_rdata = $urandom;
        b_resp_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk_i);
        cred   = pend_q.size() + ret_q.size();
        e_treq = b_req_valid && (b_req_write || cred < 3);
        e_rdy  = e_treq && b_tcdm_gnt;
        e_rv   = (ret_q.size() > 0);
        check("rnd_treq", b_tcdm_req, e_treq);
        check("rnd_rdy", b_req_ready, e_rdy);
        check("rnd_rvalid", b_resp_valid, e_rv);
        check("rnd_credits", 64'(dut_b.credits_q), 64'(cred));
        check("rnd_wen", b_tcdm_wen, b_req_write);
        check("rnd_addr", b_tcdm_addr, b_req_addr);
        check("rnd_wdata", b_tcdm_wdata, b_req_wdata);
        check("rnd_be", b_tcdm_be, b_req_be);
        if (e_rv) begin
          head = ret_q[0];
          check("rnd_rmeta", b_resp_meta, head[36:32]);
          check("rnd_rdata", b_resp_rdata, head[31:0]);
        end
        e_pop = e_rv && b_resp_ready;
        if (e_pop) void'(ret_q.pop_front());
        if (b_tcdm_vld) ret_q.push_back({pend_q.pop_front(), b_tcdm_rdata});
        if (e_rdy && !b_req_write) begin
          pend_q.push_back(b_req_meta);
          loads_done++;
          if (e_pop) simul++;
        end
        held = b_req_valid && !e_rdy;
      end
      check("rnd_drained_in_budget", (cyc < 3000), 1);
      check("rnd_grant_and_pop_seen", (simul > 0), 1);
      @(posedge clk_i); #1;
      b_req_valid = 1'b0; b_tcdm_vld = 1'b0; b_resp_ready = 1'b0;
      @(negedge clk_i);
      check("rnd_final_credits", 64'(dut_b.credits_q), 0);
      check("rnd_final_rvalid", b_resp_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
